// File: rtl/serial_tx_pkg.sv
// Shared types and width helpers for the serial result transmitter.
// SERIAL_RESULT_TX_PARITY_EN adds the PARITY state for the trailing even-parity bit.
package serial_tx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CLK_DIV    = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE   = 2'd2
`ifdef SERIAL_RESULT_TX_PARITY_EN
    ,
    PARITY = 2'd3
`endif
  } state_t;

  // bit_cnt reaches DATA_WIDTH on the last tick, div_cnt stays below CLK_DIV.
  function automatic int bit_cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  function automatic int div_cnt_width(input int clk_div);
    return $clog2(clk_div + 1);
  endfunction

  localparam int DEFAULT_BIT_CNT_W = $clog2(DEFAULT_DATA_WIDTH + 1);
  localparam int DEFAULT_DIV_CNT_W = $clog2(DEFAULT_CLK_DIV + 1);

endpackage

// File: rtl/bit_period_timer.sv
// Bit-period divider: tick is high on the last clk cycle of each CLK_DIV-cycle bit period.
// The counter holds while run is low and restarts on clear.
module bit_period_timer
  import serial_tx_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = div_cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  assign tick = run && (div_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear || tick) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_result_tx.sv
// Loads one parallel result word and shifts it out MSB first on sdo with a frame strobe.
// Optional macro SERIAL_RESULT_TX_PARITY_EN appends one even-parity bit to every frame.
module serial_result_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  sdo,
  output logic                  sframe,
  output logic                  done,
  output logic                  busy,
  output state_t                fsm_state
);

  localparam int BIT_CNT_W = bit_cnt_width(DATA_WIDTH);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  accept;
  logic                  run;
  logic                  tick;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state and ena, never on in_valid.
  assign in_ready  = (state == IDLE) && ena;
  assign accept    = in_valid && in_ready;
  assign fsm_state = state;

`ifdef SERIAL_RESULT_TX_PARITY_EN
  logic par;
  assign run = ((state == SHIFT) || (state == PARITY)) && ena;
`else
  assign run = (state == SHIFT) && ena;
`endif

  bit_period_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clear (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (tick && (bit_cnt == LAST_BIT)) begin
`ifdef SERIAL_RESULT_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef SERIAL_RESULT_TX_PARITY_EN
      PARITY: begin
        if (tick) state_nxt = DONE;
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: in_data is captured only at acceptance and then only shifted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
`ifdef SERIAL_RESULT_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (accept) begin
      shift_reg <= in_data;
      bit_cnt   <= '0;
`ifdef SERIAL_RESULT_TX_PARITY_EN
      par       <= ^in_data;
`endif
    end else if ((state == SHIFT) && tick) begin
      shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
      bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  always_comb begin
    sdo    = 1'b0;
    sframe = 1'b0;
    done   = 1'b0;
    busy   = 1'b0;
    case (state)
      SHIFT: begin
        sdo    = shift_reg[DATA_WIDTH-1];
        sframe = 1'b1;
        busy   = 1'b1;
      end
`ifdef SERIAL_RESULT_TX_PARITY_EN
      PARITY: begin
        sdo    = par;
        sframe = 1'b1;
        busy   = 1'b1;
      end
`endif
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_result_tx.sv
// Bench for serial_result_tx: an 8-bit/CLK_DIV=1 instance and a 4-bit/CLK_DIV=3 instance,
// each checked against a per-cycle queue of expected frame bits built from the sent word.
module tb_serial_result_tx;
  import serial_tx_pkg::*;

`ifdef SERIAL_RESULT_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ena = 2'b11;
  logic [1:0] in_valid = 2'b00;
  logic [1:0] in_ready, sdo, sframe, done, busy;
  logic [7:0] din_a = 8'h00;
  logic [3:0] din_b = 4'h0;
  state_t     st_a, st_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_result_tx #(.DATA_WIDTH(8), .CLK_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(din_a), .sdo(sdo[0]), .sframe(sframe[0]), .done(done[0]), .busy(busy[0]),
    .fsm_state(st_a)
  );

  serial_result_tx #(.DATA_WIDTH(4), .CLK_DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(din_b), .sdo(sdo[1]), .sframe(sframe[1]), .done(done[1]), .busy(busy[1]),
    .fsm_state(st_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int sel, input logic [7:0] v);
    if (sel == 0) din_a = v;
    else din_b = v[3:0];
  endtask

  // mode 0: ena held high; 1: random ena drops and in_valid noise; 2: 5-cycle freeze after bit 3.
  // abort_at >= 0 asserts reset once that many bit-cycles have been sent.
  task automatic send_frame(input int sel, input logic [7:0] word, input int mode,
                            input bit keep_valid, input logic [7:0] next_word,
                            input bit check_spacing, input int abort_at);
    int   w, d, lows, pops, frz, guard, acc;
    logic exp_q[$];
    logic [7:0] wm;
    w = (sel == 0) ? 8 : 4;
    d = (sel == 0) ? 1 : 3;
    wm = (sel == 0) ? word : {4'h0, word[3:0]};
    lows = 0; pops = 0; frz = 0; guard = 0;

    ena[sel] = 1'b1;
    in_valid[sel] = 1'b1;
    set_data(sel, word);
    chk("ready_before_accept", 32'(in_ready[sel]), 32'd1);
    step();
    acc = cyc - 1;
    if (check_spacing)
      chk("accept_spacing", 32'(acc - last_acc[sel]), 32'(w * d + 2 + PAR_BITS * d));
    last_acc[sel] = acc;

    if (keep_valid) set_data(sel, next_word);
    else begin
      in_valid[sel] = 1'b0;
      set_data(sel, 8'($urandom));
    end

    for (int b = w - 1; b >= 0; b--)
      repeat (d) exp_q.push_back(wm[b]);
    if (PAR_BITS == 1)
      repeat (d) exp_q.push_back(^wm);

    while (exp_q.size() > 0 && guard < 400) begin
      guard++;
      chk("sframe", 32'(sframe[sel]), 32'd1);
      chk("sdo", 32'(sdo[sel]), 32'(exp_q[0]));
      chk("busy", 32'(busy[sel]), 32'd1);
      chk("done_in_frame", 32'(done[sel]), 32'd0);
      chk("ready_in_frame", 32'(in_ready[sel]), 32'd0);
      if (pops == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sdo", 32'(sdo[sel]), 32'd0);
        chk("abort_sframe", 32'(sframe[sel]), 32'd0);
        chk("abort_busy", 32'(busy[sel]), 32'd0);
        repeat (2) begin
          step();
          chk("abort_no_done", 32'(done[sel]), 32'd0);
          chk("ready_in_reset", 32'(in_ready[sel]), 32'd1);
        end
        rst_n = 1'b1;
        return;
      end
      case (mode)
        1: begin
          ena[sel] = ($urandom_range(0, 3) != 0) || (lows >= 12);
          in_valid[sel] = keep_valid ? 1'b1 : 1'($urandom_range(0, 1));
        end
        2: begin
          if (pops == 3 * d && frz < 5) begin
            ena[sel] = 1'b0;
            in_valid[sel] = 1'b1;
            frz++;
          end else begin
            ena[sel] = 1'b1;
            in_valid[sel] = keep_valid;
          end
        end
        default: ena[sel] = 1'b1;
      endcase
      if (ena[sel]) begin
        void'(exp_q.pop_front());
        pops++;
      end else begin
        lows++;
      end
      step();
    end
    chk("frame_timeout", 32'(exp_q.size()), 32'd0);

    chk("done_pulse", 32'(done[sel]), 32'd1);
    chk("done_sframe", 32'(sframe[sel]), 32'd0);
    chk("done_sdo", 32'(sdo[sel]), 32'd0);
    chk("done_busy", 32'(busy[sel]), 32'd1);
    chk("done_latency", 32'(cyc - acc), 32'(w * d + 1 + lows + PAR_BITS * d));
    in_valid[sel] = keep_valid;
    if (mode == 1) ena[sel] = 1'($urandom_range(0, 1));
    step();
    chk("after_done", 32'(done[sel]), 32'd0);
    chk("after_busy", 32'(busy[sel]), 32'd0);
    chk("after_sframe", 32'(sframe[sel]), 32'd0);
    chk("ready_back", 32'(in_ready[sel]), 32'(ena[sel]));
    ena[sel] = 1'b1;
  endtask

  initial begin
    last_acc[0] = 0;
    last_acc[1] = 0;
    #3;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(in_ready[s]), 32'd1);
      chk("rst_sdo", 32'(sdo[s]), 32'd0);
      chk("rst_sframe", 32'(sframe[s]), 32'd0);
      chk("rst_done", 32'(done[s]), 32'd0);
      chk("rst_busy", 32'(busy[s]), 32'd0);
    end
    chk("rst_state_a", 32'(st_a), 32'(IDLE));
    chk("rst_state_b", 32'(st_b), 32'(IDLE));
    ena = 2'b00;
    #1;
    chk("rst_ready_ena_low", 32'(in_ready[0]), 32'd0);
    ena = 2'b11;
    step();
    step();
    rst_n = 1'b1;
    step();

    send_frame(0, 8'hA5, 0, 1'b0, 8'h00, 1'b0, -1);
    send_frame(1, 8'h09, 0, 1'b0, 8'h00, 1'b0, -1);
    send_frame(0, 8'hFF, 2, 1'b0, 8'h00, 1'b0, -1);
    send_frame(0, 8'h96, 0, 1'b0, 8'h00, 1'b0, 4);
    chk("post_abort_state", 32'(st_a), 32'(IDLE));
    send_frame(0, 8'h81, 0, 1'b0, 8'h00, 1'b0, -1);
    send_frame(0, 8'h3C, 0, 1'b1, 8'hC3, 1'b0, -1);
    send_frame(0, 8'hC3, 0, 1'b0, 8'h00, 1'b1, -1);
    send_frame(0, 8'h07, 0, 1'b0, 8'h00, 1'b0, -1);
    send_frame(0, 8'h03, 0, 1'b0, 8'h00, 1'b0, -1);
    send_frame(1, 8'h0E, 2, 1'b0, 8'h00, 1'b0, -1);
    send_frame(1, 8'h06, 0, 1'b1, 8'h0B, 1'b0, -1);
    send_frame(1, 8'h0B, 0, 1'b0, 8'h00, 1'b1, -1);

    for (int i = 0; i < 12; i++) begin
      send_frame(0, 8'($urandom), 1, 1'b0, 8'h00, 1'b0, -1);
      send_frame(1, 8'($urandom), 1, 1'b0, 8'h00, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_result_tx.md
Name: serial_result_tx

Overview:
- Transmit direction of the serial test interface: loads one parallel result word and shifts it out bit-serially on one pin, with a frame strobe and a completion pulse.
- Counterpart of the per-lane serial input shifters that build operands bit by bit. The receiving shift register ends with the first-sent bit in its MSB.
- Sits beside the unit under exploration in the top-level wrapper. Frees output pins for wider results.

Parameters:
- DATA_WIDTH, 32, bits per word; legal range 2..32.
- CLK_DIV, 1, clk cycles per serial bit; legal range 1..256.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  global enable; low freezes transmission.
- in_valid  input  1  word offered.
- in_ready  output  1  block can accept a word.
- in_data  input  DATA_WIDTH  word to send.
- sdo  output  1  serial data out, MSB first.
- sframe  output  1  high while sdo carries a valid frame bit.
- done  output  1  one-cycle pulse after the last bit.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, sdo=0, sframe=0, done=0, busy=0, counters=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately; no done pulse is produced.
- in_ready = (state==IDLE) && ena. It is 1 during reset while ena=1.
- FSM states:
  - IDLE: on in_valid && in_ready at an edge, load shift_reg<=in_data, bit_cnt<=0, div_cnt<=0, go to SHIFT.
  - SHIFT: sframe=1, sdo=shift_reg[DATA_WIDTH-1]; all state changes are gated by ena.
    - div_cnt counts 0..CLK_DIV-1; at CLK_DIV-1 a tick occurs.
    - On tick: shift_reg shifts left by 1, zero-filled; bit_cnt increments.
    - On the tick with bit_cnt==DATA_WIDTH-1 (last bit), go to DONE.
  - DONE: sframe=0, sdo=0, done=1 for exactly one cycle; go to IDLE unconditionally, independent of ena.
- All outputs are registered or decoded from registered state only; no combinational path from in_data or in_valid to sdo.
- Latency:
  - First bit is on sdo in the cycle after acceptance.
  - Each bit is held CLK_DIV cycles while ena=1.
  - done is high DATA_WIDTH*CLK_DIV+1 cycles after acceptance.
  - in_ready returns the cycle after done.
- ena low during SHIFT holds div_cnt, bit_cnt and shift_reg, and keeps sdo/sframe stable. The bit period is extended by the number of low cycles.
- in_valid outside IDLE is ignored. in_data is sampled only at acceptance; later changes have no effect.
- Minimum spacing between back-to-back acceptances: DATA_WIDTH*CLK_DIV+2 cycles.
- Counter widths: bit_cnt $clog2(DATA_WIDTH+1) bits, div_cnt $clog2(CLK_DIV+1) bits. Neither counter wraps inside a frame.

Optional Feature:
- Macro SERIAL_RESULT_TX_PARITY_EN.
- Defined: shift-register load also latches par = ^in_data (even parity). After the last data bit, one extra bit period of CLK_DIV cycles is sent with sdo=par and sframe=1, then DONE. done is delayed by CLK_DIV cycles; ena gating applies to the parity bit too.
- Undefined: no parity logic, frame is DATA_WIDTH bits.

Decomposition:
- Package serial_tx_pkg:
  - typedef enum for the state (IDLE, SHIFT, DONE), plus PARITY when the macro is defined.
  - Width-helper localparams for the counters.
  - A constant for the default DATA_WIDTH.
- One sub-module: bit_period_timer (CLK_DIV).
  - Inputs: clk, rst_n, run (= SHIFT && ena), clear (= acceptance).
  - Output: registered-free tick.
  - Reused by any future serial receiver.

Test Plan:
- Reset then DATA_WIDTH=8, CLK_DIV=1, accept 8'hA5 -> sdo 1,0,1,0,0,1,0,1 on cycles 1..8 with sframe=1; done=1 on cycle 9; in_ready=1 on cycle 10.
- CLK_DIV=3, DATA_WIDTH=4, accept 4'b1001 -> each bit held 3 cycles (sdo 1,1,1,0,0,0,0,0,0,1,1,1); done at cycle 13.
- Mid-frame ena=0 for 5 cycles (8'hFF, CLK_DIV=1, after bit 3) -> sdo/sframe frozen; done at cycle 14. in_valid pulsed during the freeze is not accepted.
- rst_n asserted asynchronously during bit 5 -> sdo=0, sframe=0, busy=0 before the next clk edge; no done pulse. First accept after release restarts from the MSB.
- Back-to-back: in_valid held high with 8'h3C then 8'hC3 -> second accept exactly 10 cycles after the first. The second frame is unaffected by in_data changes during the first.
- With SERIAL_RESULT_TX_PARITY_EN: 8'h07 -> 9th frame bit sdo=1; 8'h03 -> 9th bit sdo=0; done at cycle 10 (CLK_DIV=1).
